// File: rtl/alu_ctrl_pkg.sv
// alu_ctrl_pkg: shared encodings for the ALU control block.
//  - ALU control words (4-bit base encoding, zero-extended by users)
//  - R-type funct codes, ALUOp codes, mul/div op codes
//  - sequencer state enum
package alu_ctrl_pkg;

  localparam logic [3:0] CTRL_AND   = 4'b0000;
  localparam logic [3:0] CTRL_OR    = 4'b0001;
  localparam logic [3:0] CTRL_ADD   = 4'b0010;
  localparam logic [3:0] CTRL_XOR   = 4'b0011;
  localparam logic [3:0] CTRL_NOR   = 4'b0100;
  localparam logic [3:0] CTRL_SLL   = 4'b0101;
  localparam logic [3:0] CTRL_SUB   = 4'b0110;
  localparam logic [3:0] CTRL_SLT   = 4'b0111;
  localparam logic [3:0] CTRL_SLTU  = 4'b1000;
  localparam logic [3:0] CTRL_SRL   = 4'b1001;
  localparam logic [3:0] CTRL_SRA   = 4'b1010;
  localparam logic [3:0] CTRL_MFHI  = 4'b1011;
  localparam logic [3:0] CTRL_MFLO  = 4'b1100;
  localparam logic [3:0] CTRL_MDNOP = 4'b1101;

  localparam logic [5:0] F_ADD   = 6'b100000;
  localparam logic [5:0] F_SUB   = 6'b100010;
  localparam logic [5:0] F_AND   = 6'b100100;
  localparam logic [5:0] F_OR    = 6'b100101;
  localparam logic [5:0] F_XOR   = 6'b100110;
  localparam logic [5:0] F_NOR   = 6'b100111;
  localparam logic [5:0] F_SLT   = 6'b101010;
  localparam logic [5:0] F_SLTU  = 6'b101011;
  localparam logic [5:0] F_SLL   = 6'b000000;
  localparam logic [5:0] F_SRL   = 6'b000010;
  localparam logic [5:0] F_SRA   = 6'b000011;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;

  localparam logic [1:0] ALUOP_ADD = 2'b00;
  localparam logic [1:0] ALUOP_SUB = 2'b01;
  localparam logic [1:0] ALUOP_R   = 2'b10;
  localparam logic [1:0] ALUOP_SLT = 2'b11;

  localparam logic [1:0] MD_MULT  = 2'b00;
  localparam logic [1:0] MD_MULTU = 2'b01;
  localparam logic [1:0] MD_DIV   = 2'b10;
  localparam logic [1:0] MD_DIVU  = 2'b11;

  typedef enum logic [1:0] {IDLE, MULDIV, DONE} state_t;

endpackage

// File: rtl/alu_funct_decode.sv
// alu_funct_decode: combinational ALUOp/funct decode.
//  alu_op  in   ALUOP_W  main-decoder ALUOp
//  funct   in   FUNCT_W  R-type function field
//  ctrl    out  CTRL_W   ALU control word (upper bits zero)
//  is_md   out  1        funct is a multi-cycle mult/div
//  md_op   out  2        mult/div sub-op
//  illegal out  1        R-type funct is undefined (ctrl forced to and/0000)
module alu_funct_decode
  import alu_ctrl_pkg::*;
#(
  parameter int FUNCT_W = 6,
  parameter int ALUOP_W = 2,
  parameter int CTRL_W  = 4
) (
  input  logic [ALUOP_W-1:0] alu_op,
  input  logic [FUNCT_W-1:0] funct,
  output logic [CTRL_W-1:0]  ctrl,
  output logic               is_md,
  output logic [1:0]         md_op,
  output logic               illegal
);

  logic [3:0] c4;

  always_comb begin
    c4      = CTRL_AND;
    is_md   = 1'b0;
    md_op   = MD_MULT;
    illegal = 1'b0;
    case (alu_op)
      ALUOP_W'(ALUOP_ADD): c4 = CTRL_ADD;
      ALUOP_W'(ALUOP_SUB): c4 = CTRL_SUB;
      ALUOP_W'(ALUOP_SLT): c4 = CTRL_SLT;
      ALUOP_W'(ALUOP_R): begin
        case (funct)
          FUNCT_W'(F_ADD):   c4 = CTRL_ADD;
          FUNCT_W'(F_SUB):   c4 = CTRL_SUB;
          FUNCT_W'(F_AND):   c4 = CTRL_AND;
          FUNCT_W'(F_OR):    c4 = CTRL_OR;
          FUNCT_W'(F_XOR):   c4 = CTRL_XOR;
          FUNCT_W'(F_NOR):   c4 = CTRL_NOR;
          FUNCT_W'(F_SLT):   c4 = CTRL_SLT;
          FUNCT_W'(F_SLTU):  c4 = CTRL_SLTU;
          FUNCT_W'(F_SLL):   c4 = CTRL_SLL;
          FUNCT_W'(F_SRL):   c4 = CTRL_SRL;
          FUNCT_W'(F_SRA):   c4 = CTRL_SRA;
          FUNCT_W'(F_MFHI):  c4 = CTRL_MFHI;
          FUNCT_W'(F_MFLO):  c4 = CTRL_MFLO;
          FUNCT_W'(F_MULT):  begin c4 = CTRL_MDNOP; is_md = 1'b1; md_op = MD_MULT;  end
          FUNCT_W'(F_MULTU): begin c4 = CTRL_MDNOP; is_md = 1'b1; md_op = MD_MULTU; end
          FUNCT_W'(F_DIV):   begin c4 = CTRL_MDNOP; is_md = 1'b1; md_op = MD_DIV;   end
          FUNCT_W'(F_DIVU):  begin c4 = CTRL_MDNOP; is_md = 1'b1; md_op = MD_DIVU;  end
          default:           illegal = 1'b1;
        endcase
      end
      default: c4 = CTRL_AND;
    endcase
  end

  assign ctrl = CTRL_W'(c4);

endmodule

// File: rtl/alu_ctrl_seq.sv
// alu_ctrl_seq: registered ALU control with mul/div sequencing.
//  clk, reset (async, active-high), flush (sync abort)
//  valid_in/in_ready  : input handshake, in_ready = !busy
//  alu_op, funct      : decode inputs
//  ctrl, valid_out, illegal : registered single-cycle result
//  md_start, md_op, md_done, busy : mul/div unit control
module alu_ctrl_seq
  import alu_ctrl_pkg::*;
#(
  parameter int FUNCT_W       = 6,
  parameter int ALUOP_W       = 2,
  parameter int CTRL_W        = 4,
  parameter int MULDIV_CYCLES = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic               valid_in,
  output logic               in_ready,
  input  logic [ALUOP_W-1:0] alu_op,
  input  logic [FUNCT_W-1:0] funct,
  output logic [CTRL_W-1:0]  ctrl,
  output logic               valid_out,
  output logic               illegal,
  output logic               md_start,
  output logic [1:0]         md_op,
  output logic               md_done,
  output logic               busy
);

  localparam int CNT_W = $clog2(MULDIV_CYCLES);

  if (CTRL_W < 4) begin : g_bad_ctrl_w
    $error("alu_ctrl_seq: CTRL_W must be >= 4");
  end
  if (MULDIV_CYCLES < 2) begin : g_bad_md_cycles
    $error("alu_ctrl_seq: MULDIV_CYCLES must be >= 2");
  end

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CTRL_W-1:0]  dec_ctrl;
  logic               dec_is_md, dec_illegal, accept;
  logic [1:0]         dec_md_op;

  alu_funct_decode #(
    .FUNCT_W(FUNCT_W), .ALUOP_W(ALUOP_W), .CTRL_W(CTRL_W)
  ) u_dec (
    .alu_op  (alu_op),
    .funct   (funct),
    .ctrl    (dec_ctrl),
    .is_md   (dec_is_md),
    .md_op   (dec_md_op),
    .illegal (dec_illegal)
  );

  assign busy     = (state_q != IDLE);
  assign in_ready = ~busy;
  // flush wins over accept: the input beat is dropped
  assign accept   = valid_in & in_ready & ~flush;
  // a flush landing in DONE abandons the op, so suppress the pulse too
  assign md_done  = (state_q == DONE) & ~flush;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (accept && dec_is_md) begin
        state_d = MULDIV;
        cnt_d   = CNT_W'(MULDIV_CYCLES - 1);
      end
      MULDIV: begin
        if (cnt_q == '0) state_d = DONE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush) begin
      state_d = IDLE;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      ctrl      <= '0;
      illegal   <= 1'b0;
      valid_out <= 1'b0;
      md_start  <= 1'b0;
      md_op     <= 2'b00;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      valid_out <= accept;
      md_start  <= accept & dec_is_md;
      if (accept) begin
        ctrl    <= dec_ctrl;
        illegal <= dec_illegal;
        if (dec_is_md) md_op <= dec_md_op;
      end
    end
  end

endmodule

// File: tb/tb_alu_ctrl_seq.sv
module tb_alu_ctrl_seq;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       flush = 1'b0;
  logic       valid_in = 1'b0;
  logic       in_ready;
  logic [1:0] alu_op = 2'b00;
  logic [5:0] funct = 6'b000000;
  logic [3:0] ctrl;
  logic       valid_out, illegal, md_start, md_done, busy;
  logic [1:0] md_op;

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct packed { logic [3:0] c; logic ill; } exp_t;
  exp_t sb[$];

  alu_ctrl_seq #(.FUNCT_W(6), .ALUOP_W(2), .CTRL_W(4), .MULDIV_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .flush(flush), .valid_in(valid_in),
    .in_ready(in_ready), .alu_op(alu_op), .funct(funct), .ctrl(ctrl),
    .valid_out(valid_out), .illegal(illegal), .md_start(md_start),
    .md_op(md_op), .md_done(md_done), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [3:0] c, input logic ill);
    exp_t e;
    e.c = c; e.ill = ill;
    sb.push_back(e);
  endtask

  task automatic drv(input logic v, input logic [1:0] op, input logic [5:0] f, input logic fl);
    valid_in = v; alu_op = op; funct = f; flush = fl;
  endtask

  // advance one clock, sample 1 time unit after the edge, retire any result
  task automatic cyc();
    exp_t e;
    @(posedge clk);
    #1;
    if (valid_out === 1'b1) begin
      n_assert++;
      assert (sb.size() > 0) else begin
        n_fail++;
        $error("FAIL sb_unexpected observed=valid_out ctrl=%0h expected=no pending result", ctrl);
      end
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("sb_ctrl", 8'(ctrl), 8'(e.c));
        chk("sb_illegal", 8'(illegal), 8'(e.ill));
      end
    end
  endtask

  initial begin
    logic [5:0] ftab [10];
    logic [3:0] ctab [10];
    int k;
    logic seen, md_seen;

    ftab = '{6'b010000, 6'b010010, 6'b100100, 6'b100111, 6'b000000,
             6'b000010, 6'b100101, 6'b100010, 6'b101010, 6'b100000};
    ctab = '{4'b1011, 4'b1100, 4'b0000, 4'b0100, 4'b0101,
             4'b1001, 4'b0001, 4'b0110, 4'b0111, 4'b0010};

    // reset state
    @(posedge clk); @(posedge clk); #1;
    chk("rst_ctrl", 8'(ctrl), 8'h0);
    chk("rst_valid_out", 8'(valid_out), 8'h0);
    chk("rst_md_start", 8'(md_start), 8'h0);
    chk("rst_busy", 8'(busy), 8'h0);
    chk("rst_md_done", 8'(md_done), 8'h0);
    reset = 1'b0;

    // non-R alu_op ignores funct
    drv(1, 2'b00, 6'b100010, 0); push(4'b0010, 0); cyc();
    drv(1, 2'b01, 6'b100000, 0); push(4'b0110, 0); cyc();
    drv(1, 2'b11, 6'b000000, 0); push(4'b0111, 0); cyc();

    // back-to-back xor/sltu/sra
    drv(1, 2'b10, 6'b100110, 0); push(4'b0011, 0); cyc(); chk("b2b_vo1", 8'(valid_out), 8'h1);
    drv(1, 2'b10, 6'b101011, 0); push(4'b1000, 0); cyc(); chk("b2b_vo2", 8'(valid_out), 8'h1);
    drv(1, 2'b10, 6'b000011, 0); push(4'b1010, 0); cyc(); chk("b2b_vo3", 8'(valid_out), 8'h1);
    drv(0, 2'b00, 6'b0, 0); cyc(); chk("b2b_vo_end", 8'(valid_out), 8'h0);
    chk("hold_ctrl", 8'(ctrl), 8'hA);

    // illegal funct
    drv(1, 2'b10, 6'b111111, 0); push(4'b0000, 1); cyc();
    chk("illegal_flag", 8'(illegal), 8'h1);
    for (int i = 0; i < 10; i++) begin
      drv(1, 2'b10, ftab[i], 0); push(ctab[i], 0); cyc();
    end
    drv(0, 2'b00, 6'b0, 0); cyc();

    // div timing with MULDIV_CYCLES=4
    drv(1, 2'b10, 6'b011010, 0); push(4'b1101, 0); cyc();
    chk("div_md_start", 8'(md_start), 8'h1);
    chk("div_md_op", 8'(md_op), 8'h2);
    chk("div_busy1", 8'(busy), 8'h1);
    chk("div_in_ready1", 8'(in_ready), 8'h0);
    drv(0, 2'b00, 6'b0, 0);
    for (int i = 2; i <= 4; i++) begin
      cyc();
      chk("div_busy_mid", 8'(busy), 8'h1);
      chk("div_start_low", 8'(md_start), 8'h0);
      chk("div_done_low", 8'(md_done), 8'h0);
    end
    cyc();
    chk("div_done", 8'(md_done), 8'h1);
    chk("div_busy5", 8'(busy), 8'h1);
    cyc();
    chk("div_done_off", 8'(md_done), 8'h0);
    chk("div_in_ready6", 8'(in_ready), 8'h1);

    // valid_in held during busy
    drv(1, 2'b10, 6'b011000, 0); push(4'b1101, 0); cyc();
    chk("mult_md_op", 8'(md_op), 8'h0);
    drv(1, 2'b00, 6'b101010, 0); push(4'b0010, 0);
    seen = 1'b0; k = 0;
    while (!seen && k < 20) begin
      cyc(); k++;
      if (in_ready === 1'b1) seen = 1'b1;
      else chk("held_no_vo", 8'(valid_out), 8'h0);
    end
    chk("held_wait", 8'(k), 8'd5);
    cyc();
    chk("held_accept", 8'(valid_out), 8'h1);
    drv(0, 2'b00, 6'b0, 0); cyc(); cyc();
    chk("held_once", 8'(valid_out), 8'h0);

    // flush 2 cycles into mult
    drv(1, 2'b10, 6'b011001, 0); push(4'b1101, 0); cyc();
    drv(0, 2'b00, 6'b0, 0); cyc();
    chk("flush_busy_pre", 8'(busy), 8'h1);
    drv(0, 2'b00, 6'b0, 1); cyc();
    chk("flush_busy", 8'(busy), 8'h0);
    chk("flush_md_done", 8'(md_done), 8'h0);
    drv(0, 2'b00, 6'b0, 0);
    md_seen = 1'b0;
    for (int i = 0; i < 8; i++) begin cyc(); if (md_done !== 1'b0) md_seen = 1'b1; end
    chk("flush_no_done", 8'(md_seen), 8'h0);
    drv(1, 2'b00, 6'b0, 1); cyc();
    chk("flush_valid_drop", 8'(valid_out), 8'h0);
    drv(0, 2'b00, 6'b0, 0); cyc();
    chk("flush_valid_drop2", 8'(valid_out), 8'h0);

    // async reset mid mul/div
    drv(1, 2'b10, 6'b011011, 0); push(4'b1101, 0); cyc();
    drv(0, 2'b00, 6'b0, 0); cyc();
    #1 reset = 1'b1;
    #1;
    chk("arst_busy", 8'(busy), 8'h0);
    chk("arst_md_op", 8'(md_op), 8'h0);
    chk("arst_ctrl", 8'(ctrl), 8'h0);
    chk("arst_in_ready", 8'(in_ready), 8'h1);
    sb.delete();
    cyc();
    reset = 1'b0;
    md_seen = 1'b0;
    for (int i = 0; i < 8; i++) begin cyc(); if (md_done !== 1'b0 || valid_out !== 1'b0) md_seen = 1'b1; end
    chk("arst_no_done", 8'(md_seen), 8'h0);

    chk("sb_drained", 8'(sb.size()), 8'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
